// File: rtl/ldmx_timing_pkg.sv
// Shared constants and arbiter state type for the LDMX COB timing merge block.
package ldmx_timing_pkg;

  localparam int TIMING_DATA_W = 10;
  localparam int CNT_W         = 16;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arbState_t;

endpackage

// File: rtl/ldmx_timing_fifo.sv
// Synchronous first-word-fall-through FIFO, one per timing receive channel.
module ldmx_timing_fifo #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 16
) (
  input  logic              sysClk125,
  input  logic              sysClk125Rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  // The extra pointer MSB separates "full" (MSBs differ) from "empty" (MSBs equal).
  logic [AW:0]       wrPtr;
  logic [AW:0]       rdPtr;
  logic [DATA_W-1:0] mem [DEPTH];

  assign empty = (wrPtr == rdPtr);
  assign full  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign dout  = mem[rdPtr[AW-1:0]];

  always_ff @(posedge sysClk125 or posedge sysClk125Rst) begin
    if (sysClk125Rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push && !full)  wrPtr <= wrPtr + 1'b1;
      if (pop  && !empty) rdPtr <= rdPtr + 1'b1;
    end
  end

  // NOTE: the storage array has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge sysClk125) begin
    if (push && !full) mem[wrPtr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ldmx_timing_merge.sv
// Merges NUM_CH COB timing streams into one: round-robin over per-channel FIFOs,
// or the legacy registered bitwise-OR merge when OR_MODE=1.
module ldmx_timing_merge
  import ldmx_timing_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int DATA_W     = TIMING_DATA_W,
  parameter int FIFO_DEPTH = 16,
  parameter int OR_MODE    = 0
) (
  input  logic                     sysClk125,
  input  logic                     sysClk125Rst,
  input  logic [NUM_CH*DATA_W-1:0] rxData,
  input  logic [NUM_CH-1:0]        rxDataEn,
  output logic [DATA_W-1:0]        txData,
  output logic                     txDataEn,
  input  logic                     txReady,
  input  logic                     cntClr,
  output logic [NUM_CH*CNT_W-1:0]  dropCnt,
  output logic [NUM_CH-1:0]        fifoEmpty
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  arbState_t                       state;
  logic [CH_W-1:0]                 lastGrant;
  logic [CH_W-1:0]                 nextCh;
  logic [CH_W-1:0]                 idx;
  logic                            grantAvail;
  logic                            doGrant;
  logic [NUM_CH-1:0]               popVec;
  logic [NUM_CH-1:0]               fifoFull;
  logic [DATA_W-1:0]               fifoDout [NUM_CH];
  logic [DATA_W-1:0]               orData;
  logic [NUM_CH-1:0]               dropInc;
  logic [NUM_CH-1:0][CNT_W-1:0]    dropCntQ;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_fifo
    ldmx_timing_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
      .sysClk125    (sysClk125),
      .sysClk125Rst (sysClk125Rst),
      .push         ((OR_MODE == 0) && rxDataEn[k]),
      .pop          (popVec[k]),
      .din          (rxData[k*DATA_W +: DATA_W]),
      .dout         (fifoDout[k]),
      .full         (fifoFull[k]),
      .empty        (fifoEmpty[k])
    );
  end

  // Scan from farthest to nearest offset so the nearest non-empty channel after lastGrant wins.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    nextCh     = '0;
    grantAvail = 1'b0;
    idx        = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = CH_W'((int'(lastGrant) + i) % NUM_CH);
      if (!fifoEmpty[idx]) begin
        nextCh     = idx;
        grantAvail = 1'b1;
      end
    end
  end

  assign doGrant = (OR_MODE == 0) && grantAvail && ((state == IDLE) || txReady);

  always_comb begin
    popVec = '0;
    if (doGrant) popVec[nextCh] = 1'b1;
  end

  always_comb begin
    orData = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (rxDataEn[k]) orData = orData | rxData[k*DATA_W +: DATA_W];
    end
  end

  // NOTE: state registers use non-blocking assignments so every read in the block sees pre-edge values.
  always_ff @(posedge sysClk125 or posedge sysClk125Rst) begin
    if (sysClk125Rst) begin
      state     <= IDLE;
      txData    <= '0;
      txDataEn  <= 1'b0;
      lastGrant <= CH_W'(NUM_CH - 1);
    end else if (OR_MODE != 0) begin
      txData   <= orData;
      txDataEn <= |rxDataEn;
    end else if (doGrant) begin
      txData    <= fifoDout[nextCh];
      txDataEn  <= 1'b1;
      lastGrant <= nextCh;
      state     <= HOLD;
    end else if ((state == HOLD) && txReady) begin
      txDataEn <= 1'b0;
      state    <= IDLE;
    end
  end

  // In OR mode counter 0 counts collisions; otherwise each counter counts words refused by a full FIFO.
  always_comb begin
    dropInc = '0;
    if (OR_MODE != 0) dropInc[0] = ($countones(rxDataEn) > 1);
    else              dropInc    = rxDataEn & fifoFull;
  end

  always_ff @(posedge sysClk125 or posedge sysClk125Rst) begin
    if (sysClk125Rst) begin
      dropCntQ <= '0;
    end else if (cntClr) begin
      dropCntQ <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (dropInc[k] && (dropCntQ[k] != '1)) dropCntQ[k] <= dropCntQ[k] + 1'b1;
      end
    end
  end

  assign dropCnt = dropCntQ;

endmodule
